// File: rtl/index_seq_pkg.sv
// Shared phase encoding and default sizing for the index register INC/DEC sequencer.
package index_seq_pkg;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_LOW  = 3'd1,
      PH_HIGH = 3'd2,
      PH_WAIT = 3'd3,
      PH_WB   = 3'd4
   } phase_e;

   // Wide enough to count up to the largest EXTRA_WAIT of 7.
   localparam int WAIT_CNT_W     = 3;
   localparam int DEF_NUM_IDX    = 2;
   localparam int DEF_SEL_W      = 3;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_EXTRA_WAIT = 2;

endpackage

// File: rtl/index_incdec_seq_if.sv
// Control, load, read-port and strobe bundle of the index sequencer.
// The wrap strobe exists only when INDEX_INCDEC_WRAP_EN is defined.
interface index_incdec_seq_if
   import index_seq_pkg::*;
#(
   parameter int NUM_IDX    = DEF_NUM_IDX,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int EXTRA_WAIT = DEF_EXTRA_WAIT,
   parameter int SEL_W      = DEF_SEL_W
);
   logic                    start;
   logic                    is_dec;
   logic [SEL_W-1:0]        sel;
   logic                    load_en;
   logic [SEL_W-1:0]        load_sel;
   logic [2*DATA_W-1:0]     load_data;
   logic [SEL_W-1:0]        rd_sel;
   logic [2*DATA_W-1:0]     rd_data;
   logic                    busy;
   logic [EXTRA_WAIT+2:0]   xpt;
   logic                    done;
   logic                    set_cm1;
   logic                    reset_xpt;
   logic [NUM_IDX-1:0]      reset_prefix;
   logic                    illegal;
`ifdef INDEX_INCDEC_WRAP_EN
   logic                    wrap;
`endif

   modport master (
      output start, is_dec, sel, load_en, load_sel, load_data, rd_sel,
      input  rd_data, busy, xpt, done, set_cm1, reset_xpt, reset_prefix, illegal
`ifdef INDEX_INCDEC_WRAP_EN
      , input wrap
`endif
   );

   modport slave (
      input  start, is_dec, sel, load_en, load_sel, load_data, rd_sel,
      output rd_data, busy, xpt, done, set_cm1, reset_xpt, reset_prefix, illegal
`ifdef INDEX_INCDEC_WRAP_EN
      , output wrap
`endif
   );

endinterface

// File: rtl/index_byte_incdec.sv
// One byte lane of the index ALU: adds or subtracts a single carry/borrow bit.
module index_byte_incdec #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic              cin,
   input  logic              is_dec,
   output logic [DATA_W-1:0] y,
   output logic              cout
);
   logic [DATA_W:0] ext_s;

   // A DEC borrow shows up as the extension bit underflowing to one.
   always_comb begin
      if (is_dec) begin
         ext_s = {1'b0, a} - {{DATA_W{1'b0}}, cin};
      end else begin
         ext_s = {1'b0, a} + {{DATA_W{1'b0}}, cin};
      end
   end

   assign y    = ext_s[DATA_W-1:0];
   assign cout = ext_s[DATA_W];

endmodule

// File: rtl/index_incdec_seq.sv
// Index register bank plus a byte-serial INC/DEC sequencer (LOW, HIGH, waits, write-back).
// Defining INDEX_INCDEC_WRAP_EN adds a wrap strobe that pulses with done.
module index_incdec_seq
   import index_seq_pkg::*;
#(
   parameter int NUM_IDX    = DEF_NUM_IDX,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int EXTRA_WAIT = DEF_EXTRA_WAIT,
   parameter int SEL_W      = DEF_SEL_W
) (
   input logic               clk,
   input logic               reset,
   index_incdec_seq_if.slave bus
);
   localparam int REG_W = 2 * DATA_W;
   localparam int XPT_W = EXTRA_WAIT + 3;

   phase_e                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic                    is_dec_q, is_dec_d;
   logic                    carry_q, carry_d;
   logic [REG_W-1:0]        tmp_q, tmp_d;
   logic [REG_W-1:0]        bank_q [NUM_IDX];
   logic [REG_W-1:0]        bank_d [NUM_IDX];
   logic                    busy_q, busy_d;
   logic [XPT_W-1:0]        xpt_q, xpt_d;
   logic                    done_q, done_d;
   logic                    illegal_q, illegal_d;
   logic [NUM_IDX-1:0]      reset_prefix_q, reset_prefix_d;
   logic [REG_W-1:0]        src_s;
   logic [REG_W-1:0]        rd_s;
   logic [DATA_W-1:0]       alu_a_s, alu_y_s;
   logic                    alu_cin_s, alu_cout_s;
`ifdef INDEX_INCDEC_WRAP_EN
   logic                    wrap_flag_q, wrap_flag_d;
   logic                    wrap_q, wrap_d;
`endif

   index_byte_incdec #(.DATA_W(DATA_W)) u_alu (
      .a      (alu_a_s),
      .cin    (alu_cin_s),
      .is_dec (is_dec_q),
      .y      (alu_y_s),
      .cout   (alu_cout_s)
   );

   // Bank muxes for the in-flight source and the external read port.
   always_comb begin
      src_s = '0;
      rd_s  = '0;
      for (int i = 0; i < NUM_IDX; i++) begin
         src_s = (sel_q == SEL_W'(i)) ? bank_q[i] : src_s;
         rd_s  = (bus.rd_sel == SEL_W'(i)) ? bank_q[i] : rd_s;
      end
   end

   // The single byte lane sees the low byte in LOW and the high byte in HIGH.
   always_comb begin
      case (state_q)
         PH_LOW: begin
            alu_a_s   = src_s[DATA_W-1:0];
            alu_cin_s = 1'b1;
         end
         PH_HIGH: begin
            alu_a_s   = tmp_q[REG_W-1:DATA_W];
            alu_cin_s = carry_q;
         end
         default: begin
            alu_a_s   = '0;
            alu_cin_s = 1'b0;
         end
      endcase
   end

   // Phase sequencing and partial-result capture.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      sel_d     = sel_q;
      is_dec_d  = is_dec_q;
      carry_d   = carry_q;
      tmp_d     = tmp_q;
      illegal_d = 1'b0;
`ifdef INDEX_INCDEC_WRAP_EN
      wrap_flag_d = wrap_flag_q;
`endif
      case (state_q)
         PH_IDLE: begin
            if (bus.start) begin
               if (32'(bus.sel) < 32'(NUM_IDX)) begin
                  state_d  = PH_LOW;
                  sel_d    = bus.sel;
                  is_dec_d = bus.is_dec;
               end else begin
                  illegal_d = 1'b1;
               end
            end else begin
               state_d = PH_IDLE;
            end
         end
         PH_LOW: begin
            tmp_d   = {src_s[REG_W-1:DATA_W], alu_y_s};
            carry_d = alu_cout_s;
            state_d = PH_HIGH;
         end
         PH_HIGH: begin
            tmp_d   = {alu_y_s, tmp_q[DATA_W-1:0]};
            wcnt_d  = '0;
            state_d = (EXTRA_WAIT == 0) ? PH_WB : PH_WAIT;
`ifdef INDEX_INCDEC_WRAP_EN
            wrap_flag_d = alu_cout_s;
`endif
         end
         PH_WAIT: begin
            if (wcnt_q == WAIT_CNT_W'(EXTRA_WAIT - 1)) begin
               state_d = PH_WB;
            end else begin
               wcnt_d = wcnt_q + WAIT_CNT_W'(1);
            end
         end
         PH_WB: begin
            state_d = PH_IDLE;
         end
         default: begin
            state_d = PH_IDLE;
         end
      endcase
   end

   // Bank writes: write-back wins; loads aimed at the in-flight register are dropped.
   always_comb begin
      for (int i = 0; i < NUM_IDX; i++) begin
         bank_d[i] = bank_q[i];
         if ((state_q == PH_WB) && (sel_q == SEL_W'(i))) begin
            bank_d[i] = tmp_q;
         end else if (bus.load_en && (bus.load_sel == SEL_W'(i)) &&
                      !(busy_q && (bus.load_sel == sel_q))) begin
            bank_d[i] = bus.load_data;
         end else begin
            bank_d[i] = bank_q[i];
         end
      end
   end

   // Strobes are decoded from the next phase so they register in step with it.
   always_comb begin
      busy_d = (state_d != PH_IDLE);
      done_d = (state_d == PH_WB);
      xpt_d  = '0;
      xpt_d[0]       = (state_d == PH_LOW);
      xpt_d[1]       = (state_d == PH_HIGH);
      xpt_d[XPT_W-1] = (state_d == PH_WB);
      for (int i = 0; i < EXTRA_WAIT; i++) begin
         xpt_d[i+2] = (state_d == PH_WAIT) && (wcnt_d == WAIT_CNT_W'(i));
      end
      for (int i = 0; i < NUM_IDX; i++) begin
         reset_prefix_d[i] = (state_d == PH_WB) && (sel_d == SEL_W'(i));
      end
`ifdef INDEX_INCDEC_WRAP_EN
      wrap_d = (state_d == PH_WB) && wrap_flag_d;
`endif
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= PH_IDLE;
         wcnt_q         <= '0;
         sel_q          <= '0;
         is_dec_q       <= 1'b0;
         carry_q        <= 1'b0;
         tmp_q          <= '0;
         busy_q         <= 1'b0;
         xpt_q          <= '0;
         done_q         <= 1'b0;
         illegal_q      <= 1'b0;
         reset_prefix_q <= '0;
         for (int i = 0; i < NUM_IDX; i++) begin
            bank_q[i] <= '0;
         end
`ifdef INDEX_INCDEC_WRAP_EN
         wrap_flag_q <= 1'b0;
         wrap_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         sel_q          <= sel_d;
         is_dec_q       <= is_dec_d;
         carry_q        <= carry_d;
         tmp_q          <= tmp_d;
         busy_q         <= busy_d;
         xpt_q          <= xpt_d;
         done_q         <= done_d;
         illegal_q      <= illegal_d;
         reset_prefix_q <= reset_prefix_d;
         for (int i = 0; i < NUM_IDX; i++) begin
            bank_q[i] <= bank_d[i];
         end
`ifdef INDEX_INCDEC_WRAP_EN
         wrap_flag_q <= wrap_flag_d;
         wrap_q      <= wrap_d;
`endif
      end
   end

   assign bus.rd_data      = rd_s;
   assign bus.busy         = busy_q;
   assign bus.xpt          = xpt_q;
   assign bus.done         = done_q;
   assign bus.set_cm1      = done_q;
   assign bus.reset_xpt    = done_q;
   assign bus.reset_prefix = reset_prefix_q;
   assign bus.illegal      = illegal_q;
`ifdef INDEX_INCDEC_WRAP_EN
   assign bus.wrap         = wrap_q;
`endif

endmodule

// File: doc/index_incdec_seq.md
Name: index_incdec_seq

Overview:
- Multi-cycle sequencer for 16-bit INC/DEC of index registers (prefix-selected, DD/FD style), generalised to NUM_IDX registers.
- Holds the index register bank. Runs the byte-serial low/high ALU passes with carry/borrow and the configurable wait states (8(10) timing class).
- Issues end-of-instruction strobes: next-M1 set, prefix-latch clear, XPT reset.
- Sits beside the op decoder: decoder asserts start; this block owns the execution phases until done.

Parameters:
- NUM_IDX, 2, number of index registers (0=IX, 1=IY, ...); 1..8.
- DATA_W, 8, byte width of the ALU path; register width is 2*DATA_W.
- EXTRA_WAIT, 2, idle wait phases between the HIGH pass and write-back; 0..7.
- SEL_W, 3, width of register select.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin INC/DEC; sampled in IDLE only.
- is_dec  in  1  0=INC, 1=DEC; latched at start.
- sel  in  SEL_W  target register index; latched at start.
- load_en  in  1  external register write.
- load_sel  in  SEL_W  register for load.
- load_data  in  2*DATA_W  load value.
- rd_sel  in  SEL_W  read-port select.
- rd_data  out  2*DATA_W  combinational read of bank[rd_sel]; 0 if out of range.
- busy  out  1  high from the cycle after start until done inclusive.
- xpt  out  EXTRA_WAIT+3  one-hot phase vector (LOW, HIGH, WAITs, WB); all-zero in IDLE.
- done  out  1  one-cycle pulse in WB.
- set_cm1  out  1  equals done.
- reset_xpt  out  1  equals done.
- reset_prefix  out  NUM_IDX  one-hot on latched sel during WB.
- illegal  out  1  one-cycle pulse when start has sel >= NUM_IDX.

Behaviour:
- Reset: all bank entries 0, state IDLE, all outputs 0, latched carry 0.
- States and transitions:
  - IDLE -> LOW on start with a legal sel.
  - LOW: low byte = bank[sel][DATA_W-1:0] ±1. Latch carry (INC: low == all-ones) or borrow (DEC: low == 0).
  - LOW -> HIGH: high byte = high ± latched carry/borrow.
  - HIGH -> W1..W(EXTRA_WAIT) -> WB. With EXTRA_WAIT=0, HIGH -> WB.
  - WB: result committed to bank[sel]; done, set_cm1, reset_xpt and reset_prefix[sel] pulse; WB -> IDLE.
  - Partial results are held in an internal temp until WB, so the bank changes only in WB.
- Latency: start in cycle t gives done in cycle t+3+EXTRA_WAIT. The next start is accepted in the cycle after WB (back-to-back, no bubble beyond IDLE).
- Arithmetic: modulo 2^(2*DATA_W). 0xFFFF INC -> 0x0000; 0x0000 DEC -> 0xFFFF. Flags are unaffected (no flag outputs unless the optional feature is enabled).
- start while busy: ignored, no error.
- Illegal sel: illegal pulses the next cycle, state stays IDLE, nothing is written.
- load_en:
  - Applied on any cycle.
  - If load_sel equals the in-flight sel while busy, the load is dropped; WB result wins and the source value stays as latched at LOW.
  - load to other registers is accepted.
  - Out-of-range load_sel is ignored.
- Async reset mid-operation: return to IDLE immediately, no WB, no strobes, bank cleared.

Optional Feature:
- Macro: INDEX_INCDEC_WRAP_EN.
- Defined: extra output wrap (1 bit), pulsed with done when the 16-bit operation wrapped (INC from all-ones or DEC from zero).
- Not defined: port absent; no wrap logic.

Decomposition:
- Shared package index_seq_pkg: phase enum (IDLE, LOW, HIGH, WAIT, WB), wait counter width constant, NUM_IDX/SEL_W default constants.
- One sub-module: index_byte_incdec, a combinational DATA_W-wide ±carry unit returning result and carry-out. It is used once, time-multiplexed across LOW/HIGH.

Test Plan:
- load IX=0x12FF, start INC sel=0 -> done at t+5 (EXTRA_WAIT=2), IX=0x1300, reset_prefix=2'b01, set_cm1=1 for one cycle.
- load IY=0x0000, start DEC sel=1 -> IY=0xFFFF, reset_prefix=2'b10; with INDEX_INCDEC_WRAP_EN, wrap=1.
- start INC sel=0 with IX=0x00FE, second start at t+2 -> second ignored, IX=0x00FF, exactly one done.
- During INC sel=0 (IX=0x1000), load_en sel=0 data 0xAAAA at t+2 and load sel=1 data 0x5555 -> IX=0x1001, IY=0x5555.
- start sel=5 with NUM_IDX=2 -> illegal pulse, busy stays 0, bank unchanged.
- assert reset during HIGH -> busy=0, no done, all bank entries 0; xpt=0.
